// File: rtl/sand_frame_sequencer.sv
// Frame sequencer for the sand update datapath.
// Walks the packed framebuffer from the bottom row pair upwards. For each word
// it reads the floor word (row below) and the region word (current row), hands
// both to the combinational update unit, then writes floor and region back.
module sand_frame_sequencer #(
   parameter int WORDS_PER_ROW = 40,
   parameter int ROWS          = 480,
   parameter int ADDR_W        = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       region,
   output logic [31:0]       floor,
   input  logic [31:0]       new_region,
   input  logic [31:0]       new_floor,
   output logic              docalculations,
   output logic              screenbegin,
   output logic              screenend
);

   localparam int COL_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
   localparam int ROW_W = $clog2(ROWS);

   // Row base of the bottom region row; later rows are reached by subtraction.
   localparam logic [ADDR_W-1:0] BASE_INIT = ADDR_W'((ROWS - 2) * WORDS_PER_ROW);
   localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(WORDS_PER_ROW);
   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WORDS_PER_ROW - 1);
   localparam logic [ROW_W-1:0]  ROW_INIT  = ROW_W'(ROWS - 2);

   typedef enum logic [2:0] {
      IDLE,
      RD_FLOOR,
      RD_REGION,
      CAPTURE,
      CALC,
      WR_FLOOR,
      WR_REGION,
      DONE
   } state_t;

   state_t state, state_nxt;

   logic [ROW_W-1:0]  row;
   logic [COL_W-1:0]  col;
   logic [ADDR_W-1:0] base;
   logic [31:0]       new_floor_q;
   logic [31:0]       new_region_q;
   logic [ADDR_W-1:0] region_addr;
   logic [ADDR_W-1:0] floor_addr;
   logic              last_word;

   assign region_addr = base + ADDR_W'(col);
   assign floor_addr  = base + ROW_STEP + ADDR_W'(col);
   assign last_word   = (col == COL_LAST) && (row == '0);

   // Edge flags cover the whole six-cycle word slot but stay low when idle.
   assign screenbegin = busy && (col == '0);
   assign screenend   = busy && (col == COL_LAST);

   // State register; reset aborts any pass in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and memory-port decode; outputs follow state so reset drops mem_we at once.
   always_comb begin
      state_nxt      = state;
      busy           = 1'b0;
      done           = 1'b0;
      mem_addr       = '0;
      mem_we         = 1'b0;
      mem_wdata      = '0;
      docalculations = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RD_FLOOR;
            end
         end
         RD_FLOOR: begin
            busy      = 1'b1;
            mem_addr  = floor_addr;
            state_nxt = RD_REGION;
         end
         RD_REGION: begin
            busy      = 1'b1;
            mem_addr  = region_addr;
            state_nxt = CAPTURE;
         end
         CAPTURE: begin
            busy      = 1'b1;
            state_nxt = CALC;
         end
         CALC: begin
            busy           = 1'b1;
            docalculations = 1'b1;
            state_nxt      = WR_FLOOR;
         end
         WR_FLOOR: begin
            busy      = 1'b1;
            mem_addr  = floor_addr;
            mem_we    = 1'b1;
            mem_wdata = new_floor_q;
            state_nxt = WR_REGION;
         end
         WR_REGION: begin
            busy      = 1'b1;
            mem_addr  = region_addr;
            mem_we    = 1'b1;
            mem_wdata = new_region_q;
            state_nxt = last_word ? DONE : RD_FLOOR;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Word capture, update latching and row/column walk.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row          <= ROW_INIT;
         col          <= '0;
         base         <= BASE_INIT;
         region       <= '0;
         floor        <= '0;
         new_floor_q  <= '0;
         new_region_q <= '0;
      end else begin
         case (state)
            RD_REGION: begin
               // Floor read was issued last cycle, so its data is on the bus now.
               floor <= mem_rdata;
            end
            CAPTURE: begin
               region <= mem_rdata;
            end
            CALC: begin
               new_floor_q  <= new_floor;
               new_region_q <= new_region;
            end
            WR_REGION: begin
               if (col != COL_LAST) begin
                  col <= col + COL_W'(1);
               end else if (row != '0) begin
                  col  <= '0;
                  row  <= row - ROW_W'(1);
                  base <= base - ROW_STEP;
               end
            end
            DONE: begin
               row  <= ROW_INIT;
               col  <= '0;
               base <= BASE_INIT;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sand_frame_sequencer.sv
// Bench for sand_frame_sequencer: 3x2-word frame with a RAM model and a stub
// update unit, plus a 3x1-word instance for the single-column edge flags.
module tb_sand_frame_sequencer;

   localparam int ROWS = 3;
   localparam int W    = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        busy, done, mem_we, docalculations, screenbegin, screenend;
   logic [2:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata, region, floor, new_region, new_floor;

   logic        busy2, done2, mem_we2, calc2, sb2, se2;
   logic [1:0]  mem_addr2;
   logic [31:0] mem_wdata2, mem_rdata2, region2, floor2, new_region2, new_floor2;

   logic [31:0] ram  [0:7];
   logic [31:0] ram2 [0:3];
   logic [31:0] mdl  [0:7];
   logic        ram_load;
   logic        chk_on;
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;

   typedef struct packed {
      logic        busy, done, we, calc, sb, se, chk_a, chk_rf;
      logic [2:0]  addr;
      logic [31:0] wdata, rg, fl;
   } exp_t;

   exp_t exp_q[$];
   exp_t ce;

   sand_frame_sequencer #(.WORDS_PER_ROW(W), .ROWS(ROWS), .ADDR_W(3)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .region(region), .floor(floor), .new_region(new_region), .new_floor(new_floor),
      .docalculations(docalculations), .screenbegin(screenbegin), .screenend(screenend)
   );

   sand_frame_sequencer #(.WORDS_PER_ROW(1), .ROWS(3), .ADDR_W(2)) dut1 (
      .clk(clk), .reset(reset), .start(start), .busy(busy2), .done(done2),
      .mem_addr(mem_addr2), .mem_we(mem_we2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
      .region(region2), .floor(floor2), .new_region(new_region2), .new_floor(new_floor2),
      .docalculations(calc2), .screenbegin(sb2), .screenend(se2)
   );

   always #5 clk = ~clk;

   // Stub update units
   assign new_region  = ~region;
   assign new_floor   = floor + 32'd1;
   assign new_region2 = ~region2;
   assign new_floor2  = floor2 + 32'd1;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous RAMs, one-cycle read latency
   always @(posedge clk) begin
      if (ram_load) begin
         for (int i = 0; i < 8; i++) ram[3'(i)] <= 32'(i);
      end else if (mem_we) begin
         ram[mem_addr] <= mem_wdata;
      end
      mem_rdata <= ram[mem_addr];
   end

   always @(posedge clk) begin
      if (mem_we2) ram2[mem_addr2] <= mem_wdata2;
      mem_rdata2 <= ram2[mem_addr2];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp_v);
      end
   endtask

   // Append one full pass to the expected trace and update the shadow frame.
   task automatic gen_pass();
      exp_t e;
      logic [2:0] fa, ra;
      for (int r = ROWS - 2; r >= 0; r--) begin
         for (int c = 0; c < W; c++) begin
            fa = 3'((r + 1) * W + c);
            ra = 3'(r * W + c);
            for (int s = 0; s < 6; s++) begin
               e = '0;
               e.busy = 1'b1;
               e.sb = (c == 0);
               e.se = (c == W - 1);
               case (s)
                  0: begin e.chk_a = 1'b1; e.addr = fa; end
                  1: begin e.chk_a = 1'b1; e.addr = ra; end
                  3: begin e.calc = 1'b1; e.chk_rf = 1'b1; e.rg = mdl[ra]; e.fl = mdl[fa]; end
                  4: begin e.we = 1'b1; e.chk_a = 1'b1; e.addr = fa; e.wdata = mdl[fa] + 32'd1; end
                  5: begin e.we = 1'b1; e.chk_a = 1'b1; e.addr = ra; e.wdata = ~mdl[ra]; end
                  default: ;
               endcase
               exp_q.push_back(e);
            end
            mdl[fa] = mdl[fa] + 32'd1;
            mdl[ra] = ~mdl[ra];
         end
      end
      e = '0;
      e.done = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic reload();
      @(posedge clk);
      #1 ram_load = 1'b1;
      @(posedge clk);
      #1 ram_load = 1'b0;
      for (int i = 0; i < 8; i++) mdl[i] = 32'(i);
   endtask

   // Returns at the edge where the DUT leaves IDLE, with the trace queued.
   task automatic launch();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      gen_pass();
      #1 start = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && exp_q.size() > 0; k++) @(posedge clk);
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      repeat (4) @(posedge clk);
   endtask

   // Per-cycle comparison against the expected trace; empty trace means idle.
   always @(negedge clk) begin
      if (!reset && chk_on) begin
         if (exp_q.size() > 0) ce = exp_q.pop_front();
         else ce = '0;
         chk("busy", 32'(busy), 32'(ce.busy));
         chk("done", 32'(done), 32'(ce.done));
         chk("mem_we", 32'(mem_we), 32'(ce.we));
         chk("docalculations", 32'(docalculations), 32'(ce.calc));
         chk("screenbegin", 32'(screenbegin), 32'(ce.sb));
         chk("screenend", 32'(screenend), 32'(ce.se));
         if (ce.chk_a) chk("mem_addr", 32'(mem_addr), 32'(ce.addr));
         if (ce.we) chk("mem_wdata", mem_wdata, ce.wdata);
         if (ce.chk_rf) begin
            chk("region", region, ce.rg);
            chk("floor", floor, ce.fl);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cnt, done_cnt, done_at, calc_cnt, sb_cnt, se_cnt;
      int b2_cnt, sb2_cnt, se2_cnt, d2_cnt, c2_cnt;
      reset = 1'b1;
      start = 1'b0;
      ram_load = 1'b1;
      chk_on = 1'b0;
      for (int i = 0; i < 8; i++) mdl[i] = 32'(i);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_region", region, 32'd0);
      chk("rst_floor", floor, 32'd0);
      chk("rst_calc", 32'(docalculations), 32'd0);
      ram_load = 1'b0;
      reset = 1'b0;
      chk_on = 1'b1;
      repeat (2) @(posedge clk);

      // Pass A: address order, data values, pass length and flag counts
      launch();
      busy_cnt = 0; done_cnt = 0; done_at = 0; calc_cnt = 0; sb_cnt = 0; se_cnt = 0;
      b2_cnt = 0; sb2_cnt = 0; se2_cnt = 0; d2_cnt = 0; c2_cnt = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin done_cnt++; if (done_at == 0) done_at = k; end
         if (docalculations) calc_cnt++;
         if (screenbegin) sb_cnt++;
         if (screenend) se_cnt++;
         if (busy2) b2_cnt++;
         if (sb2) sb2_cnt++;
         if (se2) se2_cnt++;
         if (done2) d2_cnt++;
         if (calc2) c2_cnt++;
      end
      chk("busy_cycles", 32'(busy_cnt), 32'd24);
      chk("done_cycle", 32'(done_at), 32'd25);
      chk("done_pulses", 32'(done_cnt), 32'd1);
      chk("calc_cycles", 32'(calc_cnt), 32'd4);
      chk("begin_cycles", 32'(sb_cnt), 32'd12);
      chk("end_cycles", 32'(se_cnt), 32'd12);
      chk("w1_busy_cycles", 32'(b2_cnt), 32'd12);
      chk("w1_begin_cycles", 32'(sb2_cnt), 32'd12);
      chk("w1_end_cycles", 32'(se2_cnt), 32'd12);
      chk("w1_done_pulses", 32'(d2_cnt), 32'd1);
      chk("w1_calc_cycles", 32'(c2_cnt), 32'd2);
      drain();
      chk("ram0", ram[0], 32'hFFFF_FFFF);
      chk("ram1", ram[1], 32'hFFFF_FFFE);
      chk("ram2", ram[2], 32'hFFFF_FFFE);
      chk("ram3", ram[3], 32'hFFFF_FFFD);
      chk("ram4", ram[4], 32'd5);
      chk("ram5", ram[5], 32'd6);
      chk("model2", mdl[2], 32'hFFFF_FFFE);
      chk("model3", mdl[3], 32'hFFFF_FFFD);

      // Pass B: start pulsed while busy must not disturb the pass
      reload();
      launch();
      repeat (9) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      drain();

      // Held start: back-to-back passes with one idle cycle between
      reload();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      gen_pass();
      exp_q.push_back('0);
      gen_pass();
      repeat (30) @(posedge clk);
      #1 start = 1'b0;
      drain();

      // Reset during WR_FLOOR of the second word
      reload();
      launch();
      repeat (10) @(posedge clk);
      #1;
      chk("pre_rst_we", 32'(mem_we), 32'd1);
      chk("pre_rst_addr", 32'(mem_addr), 32'd5);
      #1 reset = 1'b1;
      exp_q.delete();
      #1;
      chk("async_rst_we", 32'(mem_we), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_done", 32'(done), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (6) @(posedge clk);
      chk("partial_ram4", ram[4], 32'd5);
      chk("partial_ram2", ram[2], 32'hFFFF_FFFD);
      chk("partial_ram5", ram[5], 32'd5);

      // Fresh full pass after the abort
      reload();
      launch();
      drain();
      chk("post_ram4", ram[4], 32'd5);
      chk("post_ram1", ram[1], 32'hFFFF_FFFE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sand_frame_sequencer.md
Name: sand_frame_sequencer

Overview:
- Drives the per-word sand update datapath. It walks the packed 2-bit-per-pixel framebuffer, fetches each region word and the floor word directly beneath it, and presents the pair with row-edge flags. It then writes the updated pair back.
- Sits between the framebuffer RAM port and the combinational update unit.
- Row r is region and row r+1 is floor. Rows are processed from bottom to top so a grain moves at most one row per pass.

Parameters:
- WORDS_PER_ROW, 40: 16-pixel words per row (640 px).
- ROWS, 480: framebuffer rows; must be ≥2.
- ADDR_W, 15: word address width; must satisfy ROWS*WORDS_PER_ROW ≤ 2^ADDR_W.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin one full-frame update pass; sampled only in IDLE
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse after last write-back
- mem_addr  out  ADDR_W  word address = row*WORDS_PER_ROW + col
- mem_we  out  1  write strobe
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data; synchronous RAM, valid one cycle after address presented
- region  out  32  current-row word to update unit
- floor  out  32  row-below word to update unit
- new_region  in  32  updated region from update unit (combinational)
- new_floor  in  32  updated floor from update unit (combinational)
- docalculations  out  1  high only in CALC
- screenbegin  out  1  col==0, held during the whole word slot
- screenend  out  1  col==WORDS_PER_ROW-1, held during the whole word slot

Behaviour:
- Reset: state=IDLE, busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0, region=0, floor=0, docalculations=0, row=ROWS-2, col=0.
- Row base is kept as a running register (no multiplier):
  - Floor address = base+WORDS_PER_ROW+col; region address = base+col.
  - Base starts at (ROWS-2)*WORDS_PER_ROW, computed as a constant.
  - Base decrements by WORDS_PER_ROW per row.
- FSM, one state per cycle, 6 cycles per word:
  - IDLE: if start, go to RD_FLOOR with busy=1.
  - RD_FLOOR: mem_addr=floor address, mem_we=0.
  - RD_REGION: mem_addr=region address; capture floor<=mem_rdata.
  - CAPTURE: capture region<=mem_rdata.
  - CALC: docalculations=1; latch new_floor and new_region into internal registers.
  - WR_FLOOR: mem_addr=floor address, mem_we=1, mem_wdata=latched new_floor.
  - WR_REGION: mem_addr=region address, mem_we=1, mem_wdata=latched new_region.
    - If col<WORDS_PER_ROW-1: col++ and go to RD_FLOOR.
    - Else if row>0: col=0, row--, base-=WORDS_PER_ROW, go to RD_FLOOR.
    - Else go to DONE.
  - DONE: done=1, busy=0, go to IDLE. Row and col are reinitialised to their reset values.
- Ordering within a row: columns left to right. Floor is always written before region for the same word slot.
- Edge cases:
  - WORDS_PER_ROW=1: screenbegin and screenend are both high.
  - ROWS=2: exactly one row pass (row 0 only).
- start is ignored while busy, including the DONE cycle. start held high continuously re-launches on the cycle after DONE.
- region/floor hold their last values outside CAPTURE/CALC. The update unit is only consumed in CALC.
- Reset asserted mid-pass: immediate return to IDLE with mem_we=0. A partial frame may remain and is accepted. No done pulse.
- Pass length: (ROWS-1)*WORDS_PER_ROW*6 busy cycles, then 1 DONE cycle.
  - Default parameters: 479*40*6 = 114,960 cycles.

Test Plan:
- Common setup for all scenarios: ROWS=3, WORDS_PER_ROW=2, RAM model with 1-cycle read latency, stub update unit (new_region=~region, new_floor=floor+1).
- Address order: pulse start; writes occur in the order (4,2),(5,3),(2,0),(3,1). Reads precede each pair in the order floor, region. busy is high for exactly 24 cycles; done pulses once on the 25th cycle.
- Data path: RAM words 0..5 = 0,1,2,3,4,5. After pass:
  - addr4=5, addr2=~2 rewritten as ~2+1 (row0 floor reads updated addr2), addr5=6.
  - addr3=~3+1, addr0=~0, addr1=~1.
  - Bench checks these exact values.
- Edge flags: screenbegin high only during col-0 slots and screenend only during col-1 slots (12 cycles each). With WORDS_PER_ROW=1, both are high in every slot.
- start while busy: pulse start at cycle 10. No restart, and the write sequence is unchanged. start held high continuously gives back-to-back passes separated by exactly one IDLE cycle.
- Reset mid-pass: assert reset during the WR_FLOOR of word 2. mem_we drops asynchronously, busy=0, no done. A new start produces the full 24-cycle sequence from address 4.
- docalculations: high exactly 4 cycles per pass, each one cycle after the corresponding CAPTURE cycle.
